// File: rtl/os_ctrl_pkg.sv
// os_ctrl_pkg: shared state encoding and SRAM bank ids
// for the output-stationary convolution sequencer.
package os_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_RD,
    X_RD,
    EXEC,
    WAIT,
    DRAIN,
    CLR,
    DONE
  } state_e;

  localparam logic [1:0] BANK_X   = 2'd0;
  localparam logic [1:0] BANK_W   = 2'd1;
  localparam logic [1:0] BANK_OUT = 2'd2;

endpackage

// File: rtl/os_nij_addr_gen.sv
// os_nij_addr_gen: maps output pixel o and kernel tap k
// to the input fmap address feeding that tap.
module os_nij_addr_gen #(
  parameter int addr_width = 8,
  parameter int in_w       = 6,
  parameter int out_w      = 4,
  parameter int k_w        = 3,
  parameter int ow         = 4,
  parameter int kw         = 4
) (
  input  logic [ow-1:0]         o,
  input  logic [kw-1:0]         k,
  output logic [addr_width-1:0] nij
);

  localparam int AW1 = addr_width + 1;

  logic [AW1-1:0] oe;
  logic [AW1-1:0] ke;
  logic [AW1-1:0] row_sum;
  logic [AW1-1:0] full;

  assign oe = AW1'(o);
  assign ke = AW1'(k);

  // fmap row = output row + kernel row; column likewise
  assign row_sum = oe / AW1'(out_w) + ke / AW1'(k_w);
  assign full    = row_sum * AW1'(in_w)
                 + oe % AW1'(out_w)
                 + ke % AW1'(k_w);

  assign nij = addr_width'(full);

endmodule

// File: rtl/os_conv_sequencer.sv
// os_conv_sequencer: owns the shared SRAM during an OS conv,
// streams weights/acts into the array, then drains psums.
module os_conv_sequencer
  import os_ctrl_pkg::*;
#(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int addr_width = 8,
  parameter int len_kij    = 9,
  parameter int len_onij   = 16,
  parameter int in_w       = 6,
  parameter int out_w      = 4,
  parameter int k_w        = 3,
  parameter int exec_lat   = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execution_mode,
  input  logic                      mem_load_complete,
  input  logic                      ext_cen,
  input  logic                      ext_wen,
  input  logic [addr_width-1:0]     ext_addr,
  input  logic [1:0]                ext_bank,
  output logic                      mem_cen,
  output logic                      mem_wen,
  output logic [addr_width-1:0]     mem_addr,
  output logic [1:0]                mem_bank,
  output logic                      w_load,
  output logic [$clog2(col)-1:0]    w_idx,
  output logic                      x_load,
  output logic [$clog2(row)-1:0]    x_idx,
  output logic                      exec,
  output logic                      out_rd,
  output logic [$clog2(row)-1:0]    out_idx,
  output logic                      psum_clr,
  output logic                      busy,
  output logic                      mode_err,
  output logic                      convolution_complete
);

  localparam int AW1  = addr_width + 1;
  localparam int CIW  = $clog2(col);
  localparam int RIW  = $clog2(row);
  localparam int NP   = len_onij / row;
  localparam int PW   = (NP > 1) ? $clog2(NP) : 1;
  localparam int KW   = (len_kij > 1) ? $clog2(len_kij) : 1;
  localparam int OW   = (len_onij > 1) ? $clog2(len_onij) : 1;
  localparam int CM1  = (row > col) ? row : col;
  localparam int CMAX = (exec_lat > CM1) ? exec_lat : CM1;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int MAX_NIJ =
    ((len_onij - 1) / out_w + (len_kij - 1) / k_w) * in_w
    + (out_w - 1) + (k_w - 1);

  if (MAX_NIJ >= (1 << addr_width)) begin : g_addr_chk
    $error("input fmap addresses exceed addr_width");
  end
  if (psum_bw < 2 * bw) begin : g_psum_chk
    $error("psum_bw too narrow for bw x bw products");
  end

  state_e state, state_d;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic [PW-1:0]  p_q, p_d;
  logic           err_d;
  logic           mode_err_q;
  logic           mlc_q, mlc_q2;
  logic           start;
  logic           w_load_q, x_load_q;
  logic [CIW-1:0] w_idx_q;
  logic [RIW-1:0] x_idx_q;

  logic [AW1-1:0]        w_full;
  logic [AW1-1:0]        o_full;
  logic [OW-1:0]         o_cur;
  logic [addr_width-1:0] x_addr;

  assign start = mlc_q & ~mlc_q2;

  assign w_full = AW1'(k_q) * AW1'(col) + AW1'(cnt_q);
  assign o_full = AW1'(p_q) * AW1'(row) + AW1'(cnt_q);
  assign o_cur  = OW'(o_full);

  os_nij_addr_gen #(
    .addr_width (addr_width),
    .in_w       (in_w),
    .out_w      (out_w),
    .k_w        (k_w),
    .ow         (OW),
    .kw         (KW)
  ) u_nij (
    .o   (o_cur),
    .k   (k_q),
    .nij (x_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      p_q        <= '0;
      mode_err_q <= 1'b0;
      mlc_q      <= 1'b0;
      mlc_q2     <= 1'b0;
      w_load_q   <= 1'b0;
      w_idx_q    <= '0;
      x_load_q   <= 1'b0;
      x_idx_q    <= '0;
    end else begin
      state      <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      p_q        <= p_d;
      mode_err_q <= err_d;
      mlc_q      <= mem_load_complete;
      mlc_q2     <= mlc_q;
      // SRAM q lags the read strobe by one cycle
      w_load_q   <= (state == W_RD);
      w_idx_q    <= cnt_q[CIW-1:0];
      x_load_q   <= (state == X_RD);
      x_idx_q    <= cnt_q[RIW-1:0];
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt_q;
    k_d      = k_q;
    p_d      = p_q;
    err_d    = mode_err_q;
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = '0;
    mem_bank = BANK_X;
    exec     = 1'b0;
    out_rd   = 1'b0;
    psum_clr = 1'b0;
    unique case (state)
      IDLE: begin
        mem_cen  = ext_cen;
        mem_wen  = ext_wen;
        mem_addr = ext_addr;
        mem_bank = ext_bank;
        cnt_d    = '0;
        k_d      = '0;
        p_d      = '0;
        if (start) begin
          if (execution_mode) state_d = W_RD;
          else err_d = 1'b1;
        end
      end
      W_RD: begin
        mem_cen  = 1'b0;
        mem_bank = BANK_W;
        mem_addr = addr_width'(w_full);
        if (cnt_q == CW'(col - 1)) begin
          cnt_d   = '0;
          state_d = X_RD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      X_RD: begin
        mem_cen  = 1'b0;
        mem_bank = BANK_X;
        mem_addr = x_addr;
        if (cnt_q == CW'(row - 1)) begin
          cnt_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        exec    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(exec_lat - 1)) begin
          cnt_d = '0;
          if (k_q == KW'(len_kij - 1)) begin
            k_d     = '0;
            state_d = DRAIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = W_RD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        out_rd   = 1'b1;
        mem_cen  = 1'b0;
        mem_wen  = 1'b0;
        mem_bank = BANK_OUT;
        mem_addr = addr_width'(o_full);
        if (cnt_q == CW'(row - 1)) begin
          cnt_d   = '0;
          state_d = CLR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLR: begin
        psum_clr = 1'b1;
        cnt_d    = '0;
        k_d      = '0;
        if (p_q == PW'(NP - 1)) begin
          state_d = DONE;
        end else begin
          p_d     = p_q + 1'b1;
          state_d = W_RD;
        end
      end
      DONE: begin
        mem_cen  = ext_cen;
        mem_wen  = ext_wen;
        mem_addr = ext_addr;
        mem_bank = ext_bank;
        if (!mem_load_complete) state_d = IDLE;
      end
    endcase
  end

  assign w_load  = w_load_q;
  assign w_idx   = w_idx_q;
  assign x_load  = x_load_q;
  assign x_idx   = x_idx_q;
  assign out_idx = cnt_q[RIW-1:0];
  assign busy    = (state != IDLE) && (state != DONE);
  assign mode_err = mode_err_q;
  assign convolution_complete = (state == DONE);

endmodule

// File: tb/tb_os_conv_sequencer.sv
// tb_os_conv_sequencer: directed vectors plus a cycle-exact
// stream model of one full two-pass convolution.
module tb_os_conv_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       execution_mode;
  logic       mem_load_complete;
  logic       ext_cen, ext_wen;
  logic [7:0] ext_addr;
  logic [1:0] ext_bank;
  logic       mem_cen, mem_wen;
  logic [7:0] mem_addr;
  logic [1:0] mem_bank;
  logic       w_load, x_load, exec, out_rd, psum_clr;
  logic [2:0] w_idx, x_idx, out_idx;
  logic       busy, mode_err, convolution_complete;

  os_conv_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .execution_mode       (execution_mode),
    .mem_load_complete    (mem_load_complete),
    .ext_cen              (ext_cen),
    .ext_wen              (ext_wen),
    .ext_addr             (ext_addr),
    .ext_bank             (ext_bank),
    .mem_cen              (mem_cen),
    .mem_wen              (mem_wen),
    .mem_addr             (mem_addr),
    .mem_bank             (mem_bank),
    .w_load               (w_load),
    .w_idx                (w_idx),
    .x_load               (x_load),
    .x_idx                (x_idx),
    .exec                 (exec),
    .out_rd               (out_rd),
    .out_idx              (out_idx),
    .psum_clr             (psum_clr),
    .busy                 (busy),
    .mode_err             (mode_err),
    .convolution_complete (convolution_complete)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cen;
    logic       wen;
    logic [1:0] bank;
    logic [7:0] addr;
    logic       wl;
    logic [2:0] wi;
    logic       xl;
    logic [2:0] xi;
    logic       ex;
    logic       ord;
    logic [2:0] oi;
    logic       clr;
    logic       busy;
    logic       cmp;
  } sv_t;

  typedef struct packed {
    int kind;
    int a;
    int idx;
  } dec_t;

  typedef struct {
    logic       cen;
    logic       wen;
    logic [7:0] addr;
    logic [1:0] bank;
    logic       ecen;
    logic       ewen;
    logic [7:0] eaddr;
    logic [1:0] ebank;
  } iv_t;

  typedef struct packed {
    int              p;
    int              k;
    logic [0:7][7:0] a;
  } xv_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  sv_t  run1 [594];
  logic [7:0] xcap [2][9][8];
  logic [7:0] outs [$];
  int   nclr;
  int   nmiss;
  iv_t  itab [4];
  xv_t  xtab [4];
  bit   ok;

  function automatic sv_t snap();
    sv_t s;
    s      = '0;
    s.cen  = mem_cen;
    s.wen  = mem_wen;
    s.bank = mem_cen ? 2'd0 : mem_bank;
    s.addr = mem_cen ? 8'd0 : mem_addr;
    s.wl   = w_load;
    s.wi   = w_load ? w_idx : 3'd0;
    s.xl   = x_load;
    s.xi   = x_load ? x_idx : 3'd0;
    s.ex   = exec;
    s.ord  = out_rd;
    s.oi   = out_rd ? out_idx : 3'd0;
    s.clr  = psum_clr;
    s.busy = busy;
    s.cmp  = convolution_complete;
    return s;
  endfunction

  function automatic sv_t idle_exp(logic c, logic w, logic [7:0] a,
                                   logic [1:0] b, logic cmp);
    sv_t e;
    e      = '0;
    e.cen  = c;
    e.wen  = w;
    e.bank = c ? 2'd0 : b;
    e.addr = c ? 8'd0 : a;
    e.cmp  = cmp;
    return e;
  endfunction

  function automatic int nij(int o, int k);
    return (o / 4 + k / 3) * 6 + o % 4 + k % 3;
  endfunction

  // kinds: 0 quiet, 1 weight read, 2 act read, 3 exec, 4 drain, 5 clr
  function automatic dec_t dec(int t);
    dec_t d;
    int p, u, k, v;
    d = '0;
    p = t / 297;
    u = t % 297;
    if (u < 288) begin
      k = u / 32;
      v = u % 32;
      if (v < 8) begin
        d.kind = 1; d.a = k * 8 + v; d.idx = v;
      end else if (v < 16) begin
        d.kind = 2; d.idx = v - 8; d.a = nij(p * 8 + v - 8, k);
      end else if (v == 16) begin
        d.kind = 3;
      end
    end else if (u < 296) begin
      d.kind = 4; d.idx = u - 288; d.a = p * 8 + u - 288;
    end else begin
      d.kind = 5;
    end
    return d;
  endfunction

  function automatic sv_t exp_at(int t);
    sv_t  e;
    dec_t d;
    e      = '0;
    e.cen  = 1'b1;
    e.wen  = 1'b1;
    e.busy = 1'b1;
    d = dec(t);
    case (d.kind)
      1: begin e.cen = 0; e.bank = 2'd1; e.addr = 8'(d.a); end
      2: begin e.cen = 0; e.bank = 2'd0; e.addr = 8'(d.a); end
      3: e.ex = 1'b1;
      4: begin
        e.cen = 0; e.wen = 0; e.bank = 2'd2; e.addr = 8'(d.a);
        e.ord = 1'b1; e.oi = 3'(d.idx);
      end
      5: e.clr = 1'b1;
      default: ;
    endcase
    if (t > 0) begin
      d = dec(t - 1);
      if (d.kind == 1) begin e.wl = 1'b1; e.wi = 3'(d.idx); end
      if (d.kind == 2) begin e.xl = 1'b1; e.xi = 3'(d.idx); end
    end
    return e;
  endfunction

  task automatic chk(string name, sv_t got, sv_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(output bit started);
    started = 1'b0;
    mem_load_complete = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (busy) begin
        started = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!started) begin
      n_fail++;
      $display("FAIL start: busy=%0b expected 1 within 6 cycles", busy);
    end
  endtask

  task automatic run_stream(input int run_id, input int stop_at);
    sv_t  act;
    dec_t d;
    for (int t = 0; t < 594; t++) begin
      act = snap();
      chk($sformatf("run%0d_t%0d", run_id, t), act, exp_at(t));
      if (run_id == 1) begin
        run1[t] = act;
        d = dec(t);
        if (d.kind == 2) xcap[t / 297][(t % 297) / 32][d.idx] = mem_addr;
        if (!act.cen && !act.wen && act.bank == 2'd2) outs.push_back(act.addr);
        if (act.clr) nclr++;
        // start edge while in WAIT of k=0 must be ignored
        if (t == 20) mem_load_complete = 1'b0;
        if (t == 24) mem_load_complete = 1'b1;
      end
      if (run_id == 3 && act !== run1[t]) nmiss++;
      if (t == stop_at) return;
      cyc();
    end
  endtask

  initial begin
    itab[0] = '{1'b0, 1'b1, 8'h12, 2'd1, 1'b0, 1'b1, 8'h12, 2'd1};
    itab[1] = '{1'b0, 1'b0, 8'hFF, 2'd2, 1'b0, 1'b0, 8'hFF, 2'd2};
    itab[2] = '{1'b1, 1'b1, 8'h5A, 2'd3, 1'b1, 1'b1, 8'h00, 2'd0};
    itab[3] = '{1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b1, 8'h00, 2'd0};
    xtab[0] = '{0, 0, '{8'd0,  8'd1,  8'd2,  8'd3,
                       8'd6,  8'd7,  8'd8,  8'd9}};
    xtab[1] = '{0, 4, '{8'd7,  8'd8,  8'd9,  8'd10,
                       8'd13, 8'd14, 8'd15, 8'd16}};
    xtab[2] = '{1, 8, '{8'd26, 8'd27, 8'd28, 8'd29,
                       8'd32, 8'd33, 8'd34, 8'd35}};
    xtab[3] = '{1, 0, '{8'd12, 8'd13, 8'd14, 8'd15,
                       8'd18, 8'd19, 8'd20, 8'd21}};
    nclr  = 0;
    nmiss = 0;

    reset = 1'b1;
    execution_mode = 1'b1;
    mem_load_complete = 1'b0;
    ext_cen = 1'b1;
    ext_wen = 1'b1;
    ext_addr = 8'h00;
    ext_bank = 2'd0;
    #1;
    chk("reset_state", snap(), idle_exp(1'b1, 1'b1, 8'h00, 2'd0, 1'b0));
    chk_int("reset_mode_err", int'(mode_err), 0);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 4; i++) begin
      ext_cen  = itab[i].cen;
      ext_wen  = itab[i].wen;
      ext_addr = itab[i].addr;
      ext_bank = itab[i].bank;
      #1;
      chk($sformatf("idle_pass%0d", i), snap(),
          idle_exp(itab[i].ecen, itab[i].ewen, itab[i].eaddr,
                   itab[i].ebank, 1'b0));
      cyc();
    end

    execution_mode = 1'b0;
    mem_load_complete = 1'b1;
    repeat (4) cyc();
    chk_int("ws_mode_err", int'(mode_err), 1);
    chk_int("ws_busy", int'(busy), 0);
    mem_load_complete = 1'b0;
    repeat (3) cyc();
    chk_int("ws_err_sticky", int'(mode_err), 1);
    execution_mode = 1'b1;

    ext_cen  = 1'b0;
    ext_wen  = 1'b1;
    ext_addr = 8'hAA;
    ext_bank = 2'd1;
    start_run(ok);
    if (ok) begin
      run_stream(1, -1);
      chk("done_entry", snap(), idle_exp(1'b0, 1'b1, 8'hAA, 2'd1, 1'b1));
      repeat (3) cyc();
      chk_int("done_hold", int'(convolution_complete), 1);
      mem_load_complete = 1'b0;
      cyc();
      chk("done_to_idle", snap(), idle_exp(1'b0, 1'b1, 8'hAA, 2'd1, 1'b0));
      for (int i = 0; i < 4; i++) begin
        for (int r = 0; r < 8; r++) begin
          chk_int($sformatf("xaddr_p%0d_k%0d_r%0d", xtab[i].p, xtab[i].k, r),
                  int'(xcap[xtab[i].p][xtab[i].k][r]), int'(xtab[i].a[r]));
        end
      end
      chk_int("out_write_cnt", outs.size(), 16);
      for (int i = 0; i < outs.size() && i < 16; i++)
        chk_int($sformatf("out_addr%0d", i), int'(outs[i]), i);
      chk_int("psum_clr_cnt", nclr, 2);
    end
    mem_load_complete = 1'b0;
    repeat (3) cyc();

    start_run(ok);
    if (ok) begin
      run_stream(2, 106);
      #3;
      reset = 1'b1;
      #1;
      chk("async_abort", snap(), idle_exp(1'b0, 1'b1, 8'hAA, 2'd1, 1'b0));
      mem_load_complete = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;
      repeat (2) cyc();
      chk_int("rst_clears_err", int'(mode_err), 0);
    end

    start_run(ok);
    if (ok) begin
      run_stream(3, -1);
      chk_int("restart_bit_exact", nmiss, 0);
      chk_int("restart_done", int'(convolution_complete), 1);
    end
    mem_load_complete = 1'b0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
